instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/thinpad_pkg.sv | 25 ++
 rtl/fetch_skid_buffer.sv | 40 ++++
 rtl/instruction_fetch.sv | 222 ++++++++++++++++++++++
 tb/tb_instruction_fetch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/thinpad_pkg.sv
// Shared types and constants for the thinpad fetch path: PC/instruction widths,
// the NOP encoding and the fetch FSM state encoding.
package thinpad_pkg;

    localparam int PC_W   = 16;
    localparam int INST_W = 16;

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [INST_W-1:0] inst_t;

    localparam inst_t NOP_INST = 16'h0800;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    // PC arithmetic is modulo 2^PC_W, so 16'hFFFF + 1 wraps to 0.
    function automatic pc_t pc_advance(input pc_t pc, input pc_t step);
        return pc + step;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer holding an instruction (and its PC) that was acked
// while decode was stalled.
module fetch_skid_buffer
    import thinpad_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_load,
    input  logic  i_clear,
    input  inst_t i_data,
    input  pc_t   i_pc,
    output inst_t o_data,
    output pc_t   o_pc,
    output logic  o_full
);

    inst_t r_data;
    pc_t   r_pc;
    logic  r_full;

    // Clear wins so that a redirect always empties the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= NOP_INST;
            r_pc   <= '0;
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_pc   <= i_pc;
            r_full <= 1'b1;
        end
    end

    assign o_data = r_data;
    assign o_pc   = r_pc;
    assign o_full = r_full;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC sequencing, imem request/ack handshake, IF/ID register.
// Defining IFETCH_PERF_CNT_EN adds the perf_fetch_cnt / perf_bubble_cnt outputs.
module instruction_fetch
    import thinpad_pkg::*;
#(
    parameter pc_t RESET_PC = 16'h0000,
    parameter pc_t PC_STEP  = 16'd1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [INST_W-1:0] imem_data,
    input  logic            mem_conflict,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [INST_W-1:0] if_inst,
    output logic [PC_W-1:0] if_pc,
    output logic            if_valid
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [15:0]     perf_fetch_cnt,
    output logic [15:0]     perf_bubble_cnt
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    pc_t   r_pc;
    pc_t   w_pc_next;
    logic  r_pending;
    logic  w_pending_next;
    pc_t   r_drain_addr;
    pc_t   w_drain_addr_next;

    inst_t r_if_inst;
    pc_t   r_if_pc;
    logic  r_if_valid;

    logic  w_req;
    pc_t   w_addr;
    logic  w_ack;
    logic  w_load_inst;
    logic  w_load_skid;
    logic  w_load_bubble;
    logic  w_skid_load;
    logic  w_skid_clear;
    inst_t w_skid_data;
    pc_t   w_skid_pc;
    logic  w_skid_full;

    fetch_skid_buffer u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (imem_data),
        .i_pc    (r_pc),
        .o_data  (w_skid_data),
        .o_pc    (w_skid_pc),
        .o_full  (w_skid_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_pending_next    = 1'b0;
        w_drain_addr_next = r_drain_addr;
        w_load_inst       = 1'b0;
        w_load_skid       = 1'b0;
        w_load_bubble     = 1'b0;
        w_skid_load       = 1'b0;
        w_skid_clear      = 1'b0;
        w_req             = 1'b0;
        w_addr            = r_pc;

        // An outstanding request keeps the bus regardless of mem_conflict.
        case (r_state)
            IDLE:  w_req = 1'b0;
            FETCH: w_req = r_pending || !mem_conflict;
            HOLD:  w_req = 1'b0;
            DRAIN: begin
                w_req  = 1'b1;
                w_addr = r_drain_addr;
            end
        endcase

        w_ack = w_req && imem_ack;

        if (redirect) begin
            w_pc_next     = redirect_pc;
            w_load_bubble = 1'b1;
            w_skid_clear  = 1'b1;
            // Unacked request in flight: its ack must still be absorbed in DRAIN.
            if (w_req && !imem_ack) begin
                w_state_next = DRAIN;
                if (r_state != DRAIN) begin
                    w_drain_addr_next = r_pc;
                end
            end else begin
                w_state_next = FETCH;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_next = FETCH;
                    if (!stall) begin
                        w_load_bubble = 1'b1;
                    end
                end
                FETCH: begin
                    if (w_ack) begin
                        w_pc_next = pc_advance(r_pc, PC_STEP);
                        if (stall) begin
                            w_skid_load  = 1'b1;
                            w_state_next = HOLD;
                        end else begin
                            w_load_inst = 1'b1;
                        end
                    end else begin
                        w_pending_next = w_req;
                        if (!stall) begin
                            w_load_bubble = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        w_state_next = FETCH;
                        w_skid_clear = 1'b1;
                        if (w_skid_full) begin
                            w_load_skid = 1'b1;
                        end else begin
                            w_load_bubble = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_ack) begin
                        w_state_next = FETCH;
                    end
                    if (!stall) begin
                        w_load_bubble = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc         <= RESET_PC;
            r_pending    <= 1'b0;
            r_drain_addr <= RESET_PC;
        end else begin
            r_pc         <= w_pc_next;
            r_pending    <= w_pending_next;
            r_drain_addr <= w_drain_addr_next;
        end
    end

    // Bubbles keep the previous if_pc; only if_inst and if_valid change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_inst  <= NOP_INST;
            r_if_pc    <= '0;
            r_if_valid <= 1'b0;
        end else if (w_load_bubble) begin
            r_if_inst  <= NOP_INST;
            r_if_valid <= 1'b0;
        end else if (w_load_inst) begin
            r_if_inst  <= imem_data;
            r_if_pc    <= r_pc;
            r_if_valid <= 1'b1;
        end else if (w_load_skid) begin
            r_if_inst  <= w_skid_data;
            r_if_pc    <= w_skid_pc;
            r_if_valid <= 1'b1;
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = w_addr;
    assign if_inst   = r_if_inst;
    assign if_pc     = r_if_pc;
    assign if_valid  = r_if_valid;

`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_bubble_cnt;

    // "Accepted" counts valid instructions written into IF/ID.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (!w_load_bubble && (w_load_inst || w_load_skid)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (w_load_bubble) begin
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
        end
    end

    assign perf_fetch_cnt  = r_fetch_cnt;
    assign perf_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a memory model acks requests with random
// latency, expected instructions are queued in program order and checked at decode.
module tb_instruction_fetch;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] PC_STEP  = 16'd1;
    localparam logic [15:0] NOP      = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0;
    logic        mem_conflict = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic [15:0] if_inst;
    logic [15:0] if_pc;
    logic        if_valid;
`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_bubble_cnt;
`endif

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .mem_conflict (mem_conflict),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_inst      (if_inst),
        .if_pc        (if_pc),
        .if_valid     (if_valid)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] inst;
    } item_t;

    item_t exp_q[$];

    int errors = 0;
    int checks = 0;

    // Reference state: next address the program stream should request, and the
    // single request the memory model has in flight.
    logic [15:0] exp_pc = RESET_PC;
    bit          mem_busy = 0;
    logic [15:0] mem_addr = 16'h0;
    int          mem_lat = 0;
    bit          mem_stale = 0;
    bit          force_en = 0;
    logic [15:0] force_val = 16'h0;
    bit          mon_en = 0;
    int          model_fetch = 0;
    int          model_bubble = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input bit st, input bit mc, input bit rd, input logic [15:0] rpc, input int lat);
        bit          acked;
        bit          acked_stale;
        logic [15:0] data;
        @(posedge clk);
        #1;
        stall        = st;
        mem_conflict = mc;
        redirect     = rd;
        redirect_pc  = rpc;
        imem_ack     = 1'b0;
        imem_data    = 16'($urandom);
        #1;
        acked       = 0;
        acked_stale = 0;
        data        = 16'h0;
        if (!mem_busy && mc) chk("conflict_no_req", 32'(imem_req), 32'd0);
        if (mem_busy) begin
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_held", 32'(imem_addr), 32'(mem_addr));
        end else if (imem_req) begin
            chk("fetch_addr", 32'(imem_addr), 32'(exp_pc));
            mem_busy  = 1;
            mem_addr  = exp_pc;
            mem_lat   = lat;
            mem_stale = 0;
        end
        if (mem_busy && imem_req) begin
            if (mem_lat == 0) begin
                data        = force_en ? force_val : 16'($urandom);
                imem_data   = data;
                imem_ack    = 1'b1;
                acked       = 1;
                acked_stale = mem_stale;
                mem_busy    = 0;
                mem_stale   = 0;
            end else begin
                mem_lat--;
            end
        end
        if (rd) begin
            exp_q.delete();
            exp_pc = rpc;
            if (mem_busy) mem_stale = 1;
        end else if (acked && !acked_stale) begin
            exp_q.push_back(item_t'({mem_addr, data}));
            exp_pc = exp_pc + PC_STEP;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'(RESET_PC));
        chk("rst_inst", 32'(if_inst), 32'(NOP));
        chk("rst_pc", 32'(if_pc), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
`ifdef IFETCH_PERF_CNT_EN
        chk("rst_perf_fetch", 32'(perf_fetch_cnt), 32'd0);
        chk("rst_perf_bubble", 32'(perf_bubble_cnt), 32'd0);
`endif
    endtask

    // Decode-side monitor: an instruction is consumed when presented valid,
    // not stalled and not flushed by a redirect.
    bit          prev_ok = 0;
    bit          prev_stall = 0;
    bit          prev_redirect = 0;
    logic [15:0] prev_inst = 16'h0;
    logic [15:0] prev_pc = 16'h0;
    logic        prev_valid = 1'b0;

    always @(negedge clk) begin
        item_t it;
        if (mon_en) begin
            if (!if_valid) chk("bubble_nop", 32'(if_inst), 32'(NOP));
            if (prev_ok && prev_stall && !prev_redirect) begin
                chk("freeze_inst", 32'(if_inst), 32'(prev_inst));
                chk("freeze_pc", 32'(if_pc), 32'(prev_pc));
                chk("freeze_valid", 32'(if_valid), 32'(prev_valid));
            end
            if (redirect) begin
                if (if_valid) model_fetch++;
                model_bubble++;
            end else if (!stall) begin
                if (if_valid) begin
                    model_fetch++;
                    if (exp_q.size() == 0) begin
                        chk("spurious_inst", 32'(if_valid), 32'd0);
                    end else begin
                        it = exp_q.pop_front();
                        chk("if_pc", 32'(if_pc), 32'(it.pc));
                        chk("if_inst", 32'(if_inst), 32'(it.inst));
                        $display("txn pc=%h inst=%h", if_pc, if_inst);
                    end
                end
                if (exp_q.size() == 0) model_bubble++;
            end
            prev_ok       = 1;
            prev_stall    = stall;
            prev_redirect = redirect;
            prev_inst     = if_inst;
            prev_pc       = if_pc;
            prev_valid    = if_valid;
        end else begin
            prev_ok      = 0;
            model_fetch  = 0;
            model_bubble = 0;
        end
    end

    initial begin
        int lat_r;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst    = 1'b1;
        mon_en = 1;

        // Back-to-back single-cycle acks from the reset PC.
        repeat (6) step(0, 0, 0, 16'h0, 0);

        // Two conflict cycles suppress new requests, then fetch resumes.
        repeat (2) step(0, 1, 0, 16'h0, 0);
        repeat (2) step(0, 0, 0, 16'h0, 0);

        // Ack of 0x6901 during a 3-cycle stall lands in the skid buffer.
        force_en  = 1;
        force_val = 16'h6901;
        step(1, 0, 0, 16'h0, 0);
        force_en  = 0;
        repeat (2) step(1, 0, 0, 16'h0, 0);
        repeat (3) step(0, 0, 0, 16'h0, 0);

        // Redirect to 0x0017 with a 3-cycle ack outstanding.
        step(0, 0, 0, 16'h0, 3);
        step(0, 0, 1, 16'h0017, 3);
        repeat (5) step(0, 0, 0, 16'h0, 0);

        // Redirect and stall together with an ack.
        step(1, 0, 1, 16'h0040, 0);
        repeat (3) step(0, 0, 0, 16'h0, 0);

        // PC wrap at 16'hFFFF.
        step(0, 0, 1, 16'hFFFE, 0);
        repeat (5) step(0, 0, 0, 16'h0, 0);

        for (int n = 0; n < 1500; n++) begin
            lat_r = ($urandom % 2 == 0) ? 0 : int'($urandom % 4);
            step(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 16) == 0,
                 16'($urandom), lat_r);
        end

        // Reset asserted with a request in flight: abandoned immediately.
        step(0, 0, 0, 16'h0, 3);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        mon_en       = 0;
        stall        = 1'b0;
        mem_conflict = 1'b0;
        redirect     = 1'b0;
        imem_ack     = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        mem_busy  = 0;
        mem_stale = 0;
        exp_pc    = RESET_PC;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1;

        for (int n = 0; n < 300; n++) begin
            lat_r = int'($urandom % 3);
            step(($urandom % 4) == 0, ($urandom % 6) == 0, ($urandom % 20) == 0,
                 16'($urandom), lat_r);
        end

        // Let outstanding work retire with no new requests.
        repeat (8) step(0, 1, 0, 16'h0, 0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        @(posedge clk);
        #1;
        mon_en = 0;
`ifdef IFETCH_PERF_CNT_EN
        chk("perf_fetch", 32'(perf_fetch_cnt), 32'(model_fetch[15:0]));
        chk("perf_bubble", 32'(perf_bubble_cnt), 32'(model_bubble[15:0]));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
